// File: rtl/alu_issue_executer.sv
// alu_issue_executer
// Integer ALU execute stage on the consumer side of the issue queue.
// Two-stage pipeline per lane: E1 (register read, E2->E1 forwarding, ALU),
// E2 (writeback to register file and completion to the ROB).
//
// Ports (all per-lane signals are packed [lane][field]):
//   clk, rst          : clock, synchronous active-high reset
//   issue_*           : issue-queue op per lane (valid, alu_cmd, op1,
//                       op2_type, op2, phys_rd, bank_addr, rob_addr);
//                       the issue interface fields are flattened to ports
//   flush             : synchronous kill of E1/E2 and of the ops on issue
//   rf_raddr1/2       : register file read addresses, driven from E1
//   rf_rdata1/2       : combinational register file read data
//   wb_*              : writeback/completion, driven from E2 registers
//   exec_count        : saturating count of ops written back
module alu_issue_executer #(
  parameter int unsigned DISPATCH_WIDTH       = 2,
  parameter int unsigned PHYS_REGS_ADDR_WIDTH = 7,
  parameter int unsigned DISPATCH_ADDR_WIDTH  = 1,
  parameter int unsigned ROB_ADDR_WIDTH       = 5
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [DISPATCH_WIDTH-1:0]                           issue_valid,
  input  logic [DISPATCH_WIDTH-1:0][3:0]                      issue_alu_cmd,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] issue_op1,
  input  logic [DISPATCH_WIDTH-1:0]                           issue_op2_type,
  input  logic [DISPATCH_WIDTH-1:0][31:0]                     issue_op2,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] issue_phys_rd,
  input  logic [DISPATCH_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0]  issue_bank_addr,
  input  logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]       issue_rob_addr,
  input  logic                                                flush,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] rf_raddr1,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DISPATCH_WIDTH-1:0][31:0]                     rf_rdata1,
  input  logic [DISPATCH_WIDTH-1:0][31:0]                     rf_rdata2,
  output logic [DISPATCH_WIDTH-1:0]                           wb_valid,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd,
  output logic [DISPATCH_WIDTH-1:0][31:0]                     wb_data,
  output logic [DISPATCH_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0]  wb_bank_addr,
  output logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]       wb_rob_addr,
  output logic [31:0]                                         exec_count
);

  localparam int unsigned DW = DISPATCH_WIDTH;
  localparam int unsigned PW = PHYS_REGS_ADDR_WIDTH;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_cmd_e;

  typedef enum logic {
    OP2_REG = 1'b0,
    OP2_IMM = 1'b1
  } op2_type_e;

  // E1 stage
  logic [DW-1:0]                          e1_valid;
  logic [DW-1:0][3:0]                     e1_alu_cmd;
  logic [DW-1:0][PW-1:0]                  e1_op1;
  logic [DW-1:0]                          e1_op2_type;
  logic [DW-1:0][31:0]                    e1_op2;
  logic [DW-1:0][PW-1:0]                  e1_phys_rd;
  logic [DW-1:0][DISPATCH_ADDR_WIDTH-1:0] e1_bank_addr;
  logic [DW-1:0][ROB_ADDR_WIDTH-1:0]      e1_rob_addr;

  // E2 stage
  logic [DW-1:0]                          e2_valid;
  logic [DW-1:0][31:0]                    e2_data;
  logic [DW-1:0][PW-1:0]                  e2_phys_rd;
  logic [DW-1:0][DISPATCH_ADDR_WIDTH-1:0] e2_bank_addr;
  logic [DW-1:0][ROB_ADDR_WIDTH-1:0]      e2_rob_addr;

  logic [31:0]         exec_count_q;
  logic [31:0]         count_next;
  logic [32:0]         count_sum;
  logic [32:0]         wb_pop;
  logic [DW-1:0][31:0] op_a;
  logic [DW-1:0][31:0] op_b;
  logic [DW-1:0][31:0] alu_res;

  // p0 always reads as zero; otherwise the lowest-index matching E2 lane
  // wins, since the register file has not been written yet for E2 results.
  function automatic logic [31:0] fwd_operand(input logic [PW-1:0] src,
                                              input logic [31:0]   rdata);
    logic [31:0] val;
    logic        hit;
    val = rdata;
    hit = 1'b0;
    for (int unsigned j = 0; j < DW; j++) begin
      if (!hit && e2_valid[j] && (e2_phys_rd[j] == src)) begin
        val = e2_data[j];
        hit = 1'b1;
      end
    end
    if (src == '0) val = '0;
    return val;
  endfunction

  function automatic logic [31:0] alu(input logic [3:0]  cmd,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] r;
    case (cmd)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {31'd0, (a < b)};
      default:  r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    rf_raddr1 = '0;
    rf_raddr2 = '0;
    op_a      = '0;
    op_b      = '0;
    alu_res   = '0;
    for (int unsigned l = 0; l < DW; l++) begin
      rf_raddr1[l] = e1_op1[l];
      rf_raddr2[l] = e1_op2[l][PW-1:0];
      op_a[l]      = fwd_operand(e1_op1[l], rf_rdata1[l]);
      if (e1_op2_type[l] == OP2_IMM) op_b[l] = e1_op2[l];
      else                           op_b[l] = fwd_operand(e1_op2[l][PW-1:0], rf_rdata2[l]);
      alu_res[l]   = alu(e1_alu_cmd[l], op_a[l], op_b[l]);
    end
  end

  always_comb begin
    wb_pop = '0;
    for (int unsigned l = 0; l < DW; l++) begin
      wb_pop = wb_pop + 33'(e2_valid[l]);
    end
    count_sum  = {1'b0, exec_count_q} + wb_pop;
    count_next = count_sum[32] ? '1 : count_sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e1_valid     <= '0;
      e1_alu_cmd   <= '0;
      e1_op1       <= '0;
      e1_op2_type  <= '0;
      e1_op2       <= '0;
      e1_phys_rd   <= '0;
      e1_bank_addr <= '0;
      e1_rob_addr  <= '0;
      e2_valid     <= '0;
      e2_data      <= '0;
      e2_phys_rd   <= '0;
      e2_bank_addr <= '0;
      e2_rob_addr  <= '0;
      exec_count_q <= '0;
    end else begin
      e1_valid     <= issue_valid & ~{DW{flush}};
      e1_alu_cmd   <= issue_alu_cmd;
      e1_op1       <= issue_op1;
      e1_op2_type  <= issue_op2_type;
      e1_op2       <= issue_op2;
      e1_phys_rd   <= issue_phys_rd;
      e1_bank_addr <= issue_bank_addr;
      e1_rob_addr  <= issue_rob_addr;
      e2_valid     <= e1_valid & ~{DW{flush}};
      e2_data      <= alu_res;
      e2_phys_rd   <= e1_phys_rd;
      e2_bank_addr <= e1_bank_addr;
      e2_rob_addr  <= e1_rob_addr;
      // The op in E2 during a flush cycle still completes, so it counts.
      exec_count_q <= count_next;
    end
  end

  assign wb_valid     = e2_valid;
  assign wb_data      = e2_data;
  assign wb_phys_rd   = e2_phys_rd;
  assign wb_bank_addr = e2_bank_addr;
  assign wb_rob_addr  = e2_rob_addr;
  assign exec_count   = exec_count_q;

endmodule

// File: tb/tb_alu_issue_executer.sv
// Directed bench for alu_issue_executer: expected completions are pushed to
// a scoreboard when issued and matched against wb_* on the falling edge of
// the cycle they are due.
module tb_alu_issue_executer;

  localparam logic [31:0] C_ADD = 0, C_SUB = 1, C_AND = 2, C_OR = 3, C_XOR = 4,
                          C_SLL = 5, C_SRL = 6, C_SRA = 7, C_SLT = 8, C_SLTU = 9;
  localparam logic [31:0] T_REG = 0, T_IMM = 1;

  logic clk;
  logic rst;
  logic flush;
  logic [1:0]        issue_valid;
  logic [1:0][3:0]   issue_alu_cmd;
  logic [1:0][6:0]   issue_op1;
  logic [1:0]        issue_op2_type;
  logic [1:0][31:0]  issue_op2;
  logic [1:0][6:0]   issue_phys_rd;
  logic [1:0][0:0]   issue_bank_addr;
  logic [1:0][4:0]   issue_rob_addr;
  logic [1:0][6:0]   rf_raddr1;
  logic [1:0][6:0]   rf_raddr2;
  logic [1:0][31:0]  rf_rdata1;
  logic [1:0][31:0]  rf_rdata2;
  logic [1:0]        wb_valid;
  logic [1:0][6:0]   wb_phys_rd;
  logic [1:0][31:0]  wb_data;
  logic [1:0][0:0]   wb_bank_addr;
  logic [1:0][4:0]   wb_rob_addr;
  logic [31:0]       exec_count;

  logic [31:0] rf [0:127];

  alu_issue_executer #(
    .DISPATCH_WIDTH(2),
    .PHYS_REGS_ADDR_WIDTH(7),
    .DISPATCH_ADDR_WIDTH(1),
    .ROB_ADDR_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .issue_valid(issue_valid),
    .issue_alu_cmd(issue_alu_cmd),
    .issue_op1(issue_op1),
    .issue_op2_type(issue_op2_type),
    .issue_op2(issue_op2),
    .issue_phys_rd(issue_phys_rd),
    .issue_bank_addr(issue_bank_addr),
    .issue_rob_addr(issue_rob_addr),
    .flush(flush),
    .rf_raddr1(rf_raddr1),
    .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1),
    .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid),
    .wb_phys_rd(wb_phys_rd),
    .wb_data(wb_data),
    .wb_bank_addr(wb_bank_addr),
    .wb_rob_addr(wb_rob_addr),
    .exec_count(exec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Register file model: combinational read, never written by the bench's
  // writeback path, so stale values are fully under stimulus control.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      rf_rdata1[l] = rf[rf_raddr1[l]];
      rf_rdata2[l] = rf[rf_raddr2[l]];
    end
  end

  typedef struct {
    int          lane;
    int          due;
    logic [31:0] data;
    logic [31:0] rd;
    logic [31:0] rob;
    logic [31:0] bank;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] pend_exp [0:1];
  logic [31:0] exp_count;
  int          n_tests;
  int          n_fail;
  logic        checking;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_lane(input int l, input logic [31:0] cmd, input logic [31:0] op1,
                          input logic [31:0] t, input logic [31:0] op2,
                          input logic [31:0] rd, input logic [31:0] rob,
                          input logic [31:0] exp);
    issue_valid[l]     = 1'b1;
    issue_alu_cmd[l]   = cmd[3:0];
    issue_op1[l]       = op1[6:0];
    issue_op2_type[l]  = t[0];
    issue_op2[l]       = op2;
    issue_phys_rd[l]   = rd[6:0];
    issue_rob_addr[l]  = rob[4:0];
    issue_bank_addr[l] = l[0:0];
    pend_exp[l]        = exp;
  endtask

  task automatic purge(input int lim);
    exp_t keep[$];
    keep = {};
    foreach (sbq[i]) if (sbq[i].due < lim) keep.push_back(sbq[i]);
    sbq = keep;
  endtask

  task automatic check_cycle();
    int          idx;
    int          npop;
    logic [32:0] s;
    npop = 0;
    for (int l = 0; l < 2; l++) begin
      idx = -1;
      for (int i = 0; i < sbq.size(); i++)
        if (sbq[i].due == edge_cnt && sbq[i].lane == l) idx = i;
      chk($sformatf("wb_valid[%0d]@%0d", l, edge_cnt), 32'(wb_valid[l]), 32'(idx >= 0));
      if (idx >= 0) begin
        chk($sformatf("wb_data[%0d]@%0d", l, edge_cnt), wb_data[l], sbq[idx].data);
        chk($sformatf("wb_phys_rd[%0d]@%0d", l, edge_cnt), 32'(wb_phys_rd[l]), sbq[idx].rd);
        chk($sformatf("wb_rob_addr[%0d]@%0d", l, edge_cnt), 32'(wb_rob_addr[l]), sbq[idx].rob);
        chk($sformatf("wb_bank_addr[%0d]@%0d", l, edge_cnt), 32'(wb_bank_addr[l]), sbq[idx].bank);
        sbq.delete(idx);
        npop++;
      end
    end
    chk($sformatf("exec_count@%0d", edge_cnt), exec_count, exp_count);
    if (rst) begin
      exp_count = '0;
    end else begin
      s = {1'b0, exp_count} + 33'(npop);
      exp_count = s[32] ? 32'hFFFF_FFFF : s[31:0];
    end
  endtask

  // Called at posedge+1: commits this cycle's issue to the scoreboard,
  // checks outputs at the falling edge, returns at the next posedge+1.
  task automatic step();
    exp_t e;
    if (rst || flush) begin
      purge(edge_cnt + 1);
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (issue_valid[l]) begin
          e.lane = l;
          e.due  = edge_cnt + 2;
          e.data = pend_exp[l];
          e.rd   = 32'(issue_phys_rd[l]);
          e.rob  = 32'(issue_rob_addr[l]);
          e.bank = 32'(issue_bank_addr[l]);
          sbq.push_back(e);
        end
      end
    end
    @(negedge clk);
    if (checking) check_cycle();
    @(posedge clk);
    #1;
    issue_valid = '0;
    flush       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic dual_issue(input logic [31:0] base);
    set_lane(0, C_ADD, 1, T_IMM, base, 50, base[4:0], base + 32'd1);
    set_lane(1, C_ADD, 1, T_IMM, base + 32'd1, 51, base[4:0] + 5'd1, base + 32'd2);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    checking = 1'b0;
    exp_count = '0;
    rst = 1'b1;
    flush = 1'b0;
    issue_valid = '0;
    issue_alu_cmd = '0;
    issue_op1 = '0;
    issue_op2_type = '0;
    issue_op2 = '0;
    issue_phys_rd = '0;
    issue_bank_addr = '0;
    issue_rob_addr = '0;
    pend_exp[0] = '0;
    pend_exp[1] = '0;
    for (int i = 0; i < 128; i++) rf[i] = 32'h1000 + 32'(i);
    rf[0]  = 32'hDEAD_BEEF;
    rf[1]  = 32'd1;
    rf[3]  = 32'h8000_0000;
    rf[4]  = 32'hFFFF_FFFF;
    rf[5]  = 32'd10;
    rf[6]  = 32'h0F0F_00FF;
    rf[9]  = 32'd100;
    rf[12] = 32'd7;
    rf[20] = 32'd999;

    @(posedge clk);
    #1;
    step();
    checking = 1'b1;
    step();
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("rst wb_valid[%0d]", l), 32'(wb_valid[l]), 32'd0);
      chk($sformatf("rst wb_data[%0d]", l), wb_data[l], 32'd0);
      chk($sformatf("rst wb_phys_rd[%0d]", l), 32'(wb_phys_rd[l]), 32'd0);
      chk($sformatf("rst wb_rob_addr[%0d]", l), 32'(wb_rob_addr[l]), 32'd0);
      chk($sformatf("rst wb_bank_addr[%0d]", l), 32'(wb_bank_addr[l]), 32'd0);
      chk($sformatf("rst rf_raddr1[%0d]", l), 32'(rf_raddr1[l]), 32'd0);
      chk($sformatf("rst rf_raddr2[%0d]", l), 32'(rf_raddr2[l]), 32'd0);
    end
    chk("rst exec_count", exec_count, 32'd0);
    rst = 1'b0;
    step();

    // Basic ADD with negative immediate
    set_lane(0, C_ADD, 5, T_IMM, 32'hFFFF_FFFD, 9, 4, 32'd7);
    step();
    idle(3);

    // E2->E1 forwarding beats stale regfile value
    set_lane(0, C_ADD, 1, T_IMM, 1, 9, 1, 32'd2);
    step();
    set_lane(1, C_SUB, 9, T_IMM, 5, 10, 2, 32'hFFFF_FFFD);
    step();
    idle(3);

    // One-cycle gap: regfile value used
    set_lane(0, C_ADD, 1, T_IMM, 1, 9, 3, 32'd2);
    step();
    step();
    set_lane(1, C_SUB, 9, T_IMM, 5, 10, 5, 32'd95);
    step();
    idle(3);

    // Forwarding on the REG operand B path
    set_lane(0, C_ADD, 5, T_IMM, 20, 12, 6, 32'd30);
    step();
    set_lane(1, C_ADD, 1, T_REG, 12, 13, 7, 32'd31);
    step();
    idle(3);

    // Both E2 lanes write p20: lowest lane wins
    set_lane(0, C_ADD, 1, T_IMM, 10, 20, 8, 32'd11);
    set_lane(1, C_ADD, 1, T_IMM, 40, 20, 9, 32'd41);
    step();
    set_lane(0, C_OR, 20, T_REG, 0, 21, 10, 32'd11);
    set_lane(1, C_ADD, 20, T_IMM, 0, 22, 11, 32'd11);
    step();
    idle(3);

    // ALU op coverage
    set_lane(0, C_SRA, 3, T_IMM, 32'h21, 30, 12, 32'hC000_0000);
    set_lane(1, C_SLT, 4, T_IMM, 1, 31, 13, 32'd1);
    step();
    set_lane(0, C_SLTU, 4, T_IMM, 1, 32, 14, 32'd0);
    set_lane(1, C_SLL, 6, T_IMM, 4, 33, 15, 32'hF0F0_0FF0);
    step();
    set_lane(0, C_SRL, 6, T_IMM, 32'h24, 34, 16, 32'h00F0_F00F);
    set_lane(1, C_AND, 6, T_IMM, 32'h0000_FFF0, 35, 17, 32'h0000_00F0);
    step();
    set_lane(0, C_XOR, 6, T_IMM, 32'hFFFF_FFFF, 36, 18, 32'hF0F0_FF00);
    set_lane(1, C_OR, 3, T_REG, 5, 37, 19, 32'h8000_000A);
    step();
    set_lane(0, C_SLT, 1, T_IMM, 32'hFFFF_FFFF, 38, 20, 32'd0);
    set_lane(1, C_SLTU, 1, T_IMM, 32'hFFFF_FFFF, 39, 21, 32'd1);
    step();
    set_lane(0, 32'hF, 6, T_IMM, 1, 40, 22, 32'd0);
    set_lane(1, C_SUB, 5, T_REG, 4, 41, 23, 32'd11);
    step();
    idle(3);

    // p0 never forwarded even when E2 targets it
    set_lane(0, C_ADD, 1, T_IMM, 54, 0, 24, 32'd55);
    step();
    set_lane(1, C_ADD, 0, T_IMM, 3, 23, 25, 32'd3);
    set_lane(0, C_ADD, 1, T_REG, 0, 24, 26, 32'd1);
    step();
    idle(3);

    // Flush: E2 ops complete, E1 and issuing ops dropped
    set_lane(0, C_ADD, 1, T_IMM, 100, 25, 27, 32'd101);
    set_lane(1, C_ADD, 1, T_IMM, 200, 26, 28, 32'd201);
    step();
    set_lane(0, C_ADD, 1, T_IMM, 2, 27, 29, 32'd3);
    set_lane(1, C_ADD, 1, T_IMM, 3, 28, 30, 32'd4);
    step();
    flush = 1'b1;
    set_lane(0, C_ADD, 1, T_IMM, 4, 29, 31, 32'd5);
    set_lane(1, C_ADD, 1, T_IMM, 5, 30, 0, 32'd6);
    step();
    idle(3);

    // Reset mid-stream after 3 cycles of dual issue
    dual_issue(32'd10);
    step();
    dual_issue(32'd12);
    step();
    dual_issue(32'd14);
    step();
    rst = 1'b1;
    step();
    chk("midrst wb_valid", 32'(wb_valid), 32'd0);
    chk("midrst exec_count", exec_count, 32'd0);
    chk("midrst rf_raddr1[0]", 32'(rf_raddr1[0]), 32'd0);
    rst = 1'b0;
    idle(3);

    // Saturation of exec_count
    force dut.exec_count_q = 32'hFFFF_FFFE;
    exp_count = 32'hFFFF_FFFE;
    #1;
    release dut.exec_count_q;
    dual_issue(32'd20);
    step();
    idle(3);
    chk("sat exec_count", exec_count, 32'hFFFF_FFFF);
    dual_issue(32'd22);
    step();
    idle(3);
    chk("sat hold exec_count", exec_count, 32'hFFFF_FFFF);
    chk("scoreboard drained", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_executer.md
# alu_issue_executer

- Consumer end of `isqIssueIf` (modport `in`).
- Takes up to `DISPATCH_WIDTH` ops per cycle from the issue queue and reads source operands from the physical register file.
- Forwards in-flight results and executes the integer ALU op.
- Drives per-lane writeback to the register file and completion to the ROB.
- Two-stage pipeline (E1 operand/execute, E2 writeback) between the issue queue and the register file/ROB.

## Interface
Parameters (values come from `parameters` package):
- `DISPATCH_WIDTH`, 2: number of lanes.
- `PHYS_REGS_ADDR_WIDTH`, 7: physical register index width.
- `DISPATCH_ADDR_WIDTH`, 1: bank address width.
- `ROB_ADDR_WIDTH`, 5: ROB index width.

Ports:
- `clk` input, 1: single clock; all state updates on rising edge.
- `rst` input, 1: reset is synchronous and active-high.
- `issue` input, `isqIssueIf.in`: `valid`, `alu_cmd`, `op1`, `op2_type`, `op2`, `phys_rd`, `bank_addr`, `rob_addr`, one per lane.
- `flush` input, 1: synchronous pipeline kill (branch mispredict).
- `rf_raddr1[lane]` output, `PHYS_REGS_ADDR_WIDTH`: source 1 read address.
- `rf_raddr2[lane]` output, `PHYS_REGS_ADDR_WIDTH`: source 2 read address.
- `rf_rdata1[lane]` input, 32: combinational read data for `rf_raddr1`, same cycle.
- `rf_rdata2[lane]` input, 32: combinational read data for `rf_raddr2`, same cycle.
- `wb_valid[lane]` output, 1: writeback/completion valid.
- `wb_phys_rd[lane]` output, `PHYS_REGS_ADDR_WIDTH`: destination register.
- `wb_data[lane]` output, 32: result.
- `wb_bank_addr[lane]` output, `DISPATCH_ADDR_WIDTH`: ROB bank.
- `wb_rob_addr[lane]` output, `ROB_ADDR_WIDTH`: ROB entry.
- `exec_count` output, 32: total ops written back, saturating.

## Operation
Per-lane pipeline, lanes fully independent except for forwarding.

Issue to E1:
- Each edge, E1 lane register loads the `issue` fields.
- `e1_valid <= issue.valid & ~flush`.

E1 register read:
- `rf_raddr1 = e1_op1`.
- `rf_raddr2 = e1_op2[PHYS_REGS_ADDR_WIDTH-1:0]`.
- Addresses are driven even when `e1_valid=0`.

Operand A, in priority order:
1. `e1_op1==0` gives 0.
2. Else the lowest-index E2 lane with `e2_valid` and `e2_phys_rd==e1_op1` supplies its `e2_data`.
3. Else `rf_rdata1`.

Operand B:
- `op2_type==IMM`: `e1_op2` (already sign-extended by decode).
- `op2_type==REG`: same priority rule as operand A, applied to `e1_op2[PHYS_REGS_ADDR_WIDTH-1:0]` and `rf_rdata2`.

ALU, 32-bit, wrap-around arithmetic, no flags:
- ADD `a+b`; SUB `a-b`.
- AND, OR, XOR.
- SLL `a<<b[4:0]`; SRL logical; SRA arithmetic.
- SLT signed compare, result 1 or 0; SLTU unsigned compare.
- Undefined `alu_cmd` gives result 0; the op still writes back.

E1 to E2:
- `e2_valid <= e1_valid & ~flush`.
- `e2_data`, `e2_phys_rd`, `e2_bank_addr`, `e2_rob_addr` load from E1.

E2 outputs:
- `wb_*` are driven directly from E2 registers.
- The register file is written at the end of the E2 cycle and is not write-through. The E2 bypass therefore covers the only hazard window: a dependent op issued one cycle after its producer.
- A dependent op issued two or more cycles later reads the register file.

`exec_count`:
- Adds the popcount of `wb_valid` each cycle.
- Saturates at `32'hFFFF_FFFF`.
- Not cleared by `flush`.

## Timing
- Issue accepted at edge N; result on `wb_*` during cycle N+1 to N+2 (`wb_valid` high in the cycle after E1). Fixed 2-cycle latency.
- No backpressure: `issue.valid` is always accepted, with 1 op per lane per cycle sustained.
- Forwarding is E2 to E1 only, combinational within the E1 cycle.
- `flush`:
  - Clears `e1_valid` and `e2_valid` at the same edge.
  - Ops presented on `issue` in the flush cycle are dropped.
  - `wb_valid` is 0 the cycle after flush.
  - The E2 op visible during the flush cycle still writes back in that cycle.
- Reset values, at the first edge with `rst=1`:
  - `e1_valid` = 0 and `e2_valid` = 0, so all `wb_valid` = 0.
  - `wb_data`, `wb_phys_rd`, `wb_bank_addr`, `wb_rob_addr` = 0.
  - `exec_count` = 0.
- `rst` has priority over `flush` and `issue`; mid-operation reset discards all in-flight ops.
- `rf_raddr*` follow E1 registers and are 0 after reset.

## Test plan
- Lane 0 ADD, p5=10 in regfile, IMM `op2=-3`, `phys_rd=p9`, rob 4 -> `wb_valid[0]=1` exactly 2 cycles later, `wb_data=7`, `wb_phys_rd=9`, `wb_rob_addr=4`.
- Back-to-back dependency: cycle N lane 0 `p9=ADD(p1=1,IMM 1)`; N+1 lane 1 `SUB(p9,IMM 5)` with regfile p9 stale = 100 -> lane 1 result `-3` (`0xFFFF_FFFD`), proving forwarding. Repeat with a one-cycle gap -> regfile value is used.
- Shifts and compares: SRA `0x8000_0000` by `op2=0x21` -> `0xC000_0000` (uses `[4:0]`=1); SLT `-1<1` -> 1; SLTU `0xFFFF_FFFF<1` -> 0.
- Flush with both lanes valid in E1 and E2 plus new issue -> E2 ops complete in the flush cycle; nothing else writes back; `exec_count` counts only the 2 E2 ops.
- Source p0 with E2 writing p0 with value 55 -> operand is 0, not 55.
- Reset mid-stream after 3 cycles of dual issue -> all `wb_valid=0` and `exec_count=0` next cycle. Separately, preload `exec_count` to `0xFFFF_FFFE`, then dual writeback -> `0xFFFF_FFFF`.
